// File: rtl/branch_predictor.sv
// Direct-mapped table of 2-bit saturating counters for conditional branch prediction.
// The lookup is combinational. An update is written on the clock edge, so a lookup in the same cycle returns the value from before the update.
module branch_predictor #(
  parameter int PC_WIDTH = 32,
  parameter int N_SETS   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] pc_guess,
  input  logic                is_br_guess,
  output logic                br_pred_taken,
  input  logic [PC_WIDTH-1:0] pc_check,
  input  logic                is_br_check,
  input  logic                br_taken_check
);

  localparam int IDX   = $clog2(N_SETS);
  localparam int TAG_W = PC_WIDTH - IDX - 2;

  logic             valid_q [N_SETS];
  logic [TAG_W-1:0] tag_q   [N_SETS];
  logic [1:0]       ctr_q   [N_SETS];

  logic [IDX-1:0]   g_idx, c_idx;
  logic [TAG_W-1:0] g_tag, c_tag;
  logic             g_hit, c_hit;
  logic [1:0]       c_ctr;
  logic [1:0]       ctr_d;

  // The two low PC bits are the byte offset within the instruction word, so they do not affect indexing.
  logic unused_lsb;
  assign unused_lsb = ^{pc_guess[1:0], pc_check[1:0]};

  assign g_idx = pc_guess[IDX+1:2];
  assign g_tag = pc_guess[PC_WIDTH-1:IDX+2];
  assign c_idx = pc_check[IDX+1:2];
  assign c_tag = pc_check[PC_WIDTH-1:IDX+2];

  assign g_hit = valid_q[g_idx] && (tag_q[g_idx] == g_tag);
  assign c_hit = valid_q[c_idx] && (tag_q[c_idx] == c_tag);
  assign c_ctr = ctr_q[c_idx];

  always_comb begin
    br_pred_taken = is_br_guess && g_hit && ctr_q[g_idx][1];
  end

  always_comb begin
    ctr_d = c_ctr;
    if (!c_hit) begin
      ctr_d = br_taken_check ? 2'b10 : 2'b01;
    end else if (br_taken_check) begin
      if (c_ctr != '1) ctr_d = c_ctr + 2'd1;
    end else begin
      if (c_ctr != '0) ctr_d = c_ctr - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_SETS; i++) begin
        valid_q[i[IDX-1:0]] <= 1'b0;
        tag_q[i[IDX-1:0]]   <= '0;
        ctr_q[i[IDX-1:0]]   <= 2'b01;
      end
    end else if (is_br_check) begin
      valid_q[c_idx] <= 1'b1;
      tag_q[c_idx]   <= c_tag;
      ctr_q[c_idx]   <= ctr_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor. A reference model of the table is checked against the DUT on every cycle.
// Hand-computed expectations also check the model.
module tb_branch_predictor;

  localparam int PCW = 32;
  localparam int NS  = 32;
  localparam int IDXB = $clog2(NS);

  logic           clk = 1'b0;
  logic           rst;
  logic [PCW-1:0] pc_guess;
  logic           is_br_guess;
  logic           br_pred_taken;
  logic [PCW-1:0] pc_check;
  logic           is_br_check;
  logic           br_taken_check;

  int errors = 0;
  int checks = 0;

  branch_predictor #(.PC_WIDTH(PCW), .N_SETS(NS)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_guess       (pc_guess),
    .is_br_guess    (is_br_guess),
    .br_pred_taken  (br_pred_taken),
    .pc_check       (pc_check),
    .is_br_check    (is_br_check),
    .br_taken_check (br_taken_check)
  );

  always #5 clk = ~clk;

  // Reference model: each slot stores the full tag value (the PC divided by 4*NS) and a counter value in the range 0..3.
  bit          m_valid [NS];
  longint      m_tag   [NS];
  int          m_ctr   [NS];
  bit          m_live = 1'b0;

  function automatic int slot_of(input logic [PCW-1:0] pc);
    return int'((longint'(pc) / 4) % NS);
  endfunction

  function automatic longint tag_of(input logic [PCW-1:0] pc);
    return longint'(pc) / (4 * NS);
  endfunction

  function automatic bit model_pred(input logic [PCW-1:0] pc, input logic br);
    int s;
    s = slot_of(pc);
    return br && m_valid[s] && (m_tag[s] == tag_of(pc)) && (m_ctr[s] >= 2);
  endfunction

  always @(posedge clk) begin
    if (rst === 1'b1) begin
      for (int k = 0; k < NS; k++) begin
        m_valid[k] = 1'b0;
        m_tag[k]   = 0;
        m_ctr[k]   = 1;
      end
      m_live = 1'b1;
    end else if (m_live && is_br_check === 1'b1) begin
      int s;
      s = slot_of(pc_check);
      if (m_valid[s] && m_tag[s] == tag_of(pc_check)) begin
        if (br_taken_check) m_ctr[s] = (m_ctr[s] == 3) ? 3 : m_ctr[s] + 1;
        else                m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
      end else begin
        m_valid[s] = 1'b1;
        m_tag[s]   = tag_of(pc_check);
        m_ctr[s]   = br_taken_check ? 2 : 1;
      end
    end
  end

  // The model is compared with the DUT at each falling edge, away from the rising edge where state changes.
  always @(negedge clk) begin
    if (m_live) begin
      bit exp;
      exp = model_pred(pc_guess, is_br_guess);
      checks++;
      if (br_pred_taken !== exp) begin
        errors++;
        $display("FAIL model_cmp t=%0t pc_guess=%h br=%b got=%b want=%b",
                 $time, pc_guess, is_br_guess, br_pred_taken, exp);
      end
    end
  end

  // Drive one cycle of inputs. If exp >= 0, check the prediction before the next rising edge.
  task automatic step(input logic r, input logic [PCW-1:0] gp, input logic gb,
                      input logic [PCW-1:0] cp, input logic cb, input logic ct,
                      input int exp, input string nm);
    rst = r; pc_guess = gp; is_br_guess = gb;
    pc_check = cp; is_br_check = cb; br_taken_check = ct;
    #3;
    if (exp >= 0) begin
      checks++;
      if (br_pred_taken !== exp[0]) begin
        errors++;
        $display("FAIL %s got=%b want=%0d", nm, br_pred_taken, exp);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; pc_guess = '0; is_br_guess = 1'b0;
    pc_check = '0; is_br_check = 1'b0; br_taken_check = 1'b0;
    @(posedge clk); #1;

    // Cold miss, then allocation, then saturation.
    step(1'b1, 32'h100, 1'b1, 32'h0,   1'b0, 1'b0, -1, "reset");
    step(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 1'b1,  0, "cold_miss");
    step(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 1'b1,  1, "alloc_taken");
    step(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 1'b1,  1, "train_sat1");
    step(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 1'b0,  1, "sat_strong_t");
    step(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 1'b0,  1, "sat_weak_t");
    step(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 1'b0,  0, "sat_weak_nt");
    step(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 1'b0,  0, "sat_strong_nt");
    step(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 1'b1,  0, "sat_floor");
    step(1'b0, 32'h100, 1'b1, 32'h0,   1'b0, 1'b0,  0, "floor_plus1");

    // Aliasing: 0x100 and 0x180 index the same slot but have different tags.
    step(1'b1, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, -1, "reset");
    step(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 1'b1,  0, "alias_cold");
    step(1'b0, 32'h180, 1'b1, 32'h0,   1'b0, 1'b0,  0, "alias_no_borrow");
    step(1'b0, 32'h100, 1'b1, 32'h180, 1'b1, 1'b0,  1, "alias_pre");
    step(1'b0, 32'h100, 1'b1, 32'h0,   1'b0, 1'b0,  0, "alias_evicted");
    step(1'b0, 32'h180, 1'b1, 32'h0,   1'b0, 1'b0,  0, "alias_weak_nt");

    // A guess and a check to the same slot in the same cycle.
    step(1'b0, 32'h0,   1'b0, 32'h200, 1'b1, 1'b0, -1, "simul_setup");
    step(1'b0, 32'h200, 1'b1, 32'h200, 1'b1, 1'b1,  0, "simul_pre");
    step(1'b0, 32'h200, 1'b1, 32'h0,   1'b0, 1'b0,  1, "simul_post");

    // Entries are independent, and the two low PC bits are ignored.
    step(1'b0, 32'h0,   1'b0, 32'h104, 1'b1, 1'b1, -1, "indep_train1");
    step(1'b0, 32'h0,   1'b0, 32'h104, 1'b1, 1'b1, -1, "indep_train2");
    step(1'b0, 32'h104, 1'b1, 32'h108, 1'b1, 1'b0,  1, "indep_pre");
    step(1'b0, 32'h104, 1'b1, 32'h0,   1'b0, 1'b0,  1, "indep_hold");
    step(1'b0, 32'h107, 1'b1, 32'h0,   1'b0, 1'b0,  1, "low_bits_ignored");
    step(1'b0, 32'h108, 1'b1, 32'h0,   1'b0, 1'b0,  0, "indep_neighbor");
    step(1'b0, 32'h104, 1'b0, 32'h104, 1'b0, 1'b0,  0, "no_guess");
    step(1'b0, 32'h104, 1'b1, 32'h104, 1'b0, 1'b0,  1, "check_ignored");

    // Reset in the middle of operation, with a check in the same cycle that must be dropped.
    step(1'b0, 32'h0,   1'b0, 32'h100, 1'b1, 1'b1, -1, "mid_train1");
    step(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 1'b1,  1, "mid_train2");
    step(1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 1'b1, -1, "mid_reset");
    step(1'b0, 32'h100, 1'b1, 32'h0,   1'b0, 1'b0,  0, "post_reset_100");
    step(1'b0, 32'h104, 1'b1, 32'h0,   1'b0, 1'b0,  0, "post_reset_104");

    // Random traffic over a small set of PCs. This makes hits, aliasing and collisions frequent.
    for (int n = 0; n < 3000; n++) begin
      logic [PCW-1:0] gp, cp;
      gp = PCW'(($urandom_range(0, 3) << (IDXB + 2)) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
      cp = PCW'(($urandom_range(0, 3) << (IDXB + 2)) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) gp = $urandom;
      if ($urandom_range(0, 15) == 0) cp = gp;
      step(($urandom_range(0, 99) == 0), gp, 1'($urandom), cp, 1'($urandom), 1'($urandom), -1, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
